// File: rtl/aes_pkg.sv
// aes_pkg: shared AES tables, GF(2^8) helpers, round-count mapping and FSM encoding
package aes_pkg;
  typedef enum logic {IDLE, ROUND} fsm_e;
  localparam logic [2047:0] SBOX = 2048'h637c777bf26b6fc53001672bfed7ab76_ca82c97dfa5947f0add4a2af9ca472c0_b7fd9326363ff7cc34a5e5f171d83115_04c723c31896059a071280e2eb27b275_09832c1a1b6e5aa0523bd6b329e32f84_53d100ed20fcb15b6acbbe394a4c58cf_d0efaafb434d338545f9027f503c9fa8_51a3408f929d38f5bcb6da2110fff3d2_cd0c13ec5f974417c4a77e3d645d1973_60814fdc222a908846eeb814de5e0bdb_e0323a0a4906245cc2d3ac629195e479_e7c8376d8dd54ea96c56f4ea657aae08_ba78252e1ca6b4c6e8dd741f4bbd8b8a_703eb5664803f60e613557b986c11d9e_e1f8981169d98e949b1e87e9ce5528df_8ca1890dbfe6426841992d0fb054bb16;
  localparam logic [79:0] RCON = 80'h01020408102040801b36;
  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[8*(255-int'(b)) +: 8];
  endfunction
  function automatic logic [7:0] rcon(input int i);
    return RCON[8*(10-i) +: 8];
  endfunction
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction
  function automatic int nr_of(input int n);
    return n == 128 ? 10 : (n == 192 ? 12 : 14);
  endfunction
endpackage

// File: rtl/aes_enc_round.sv
// aes_enc_round: one combinational AES encryption round; final_round skips MixColumns
module aes_enc_round import aes_pkg::*; (
  input  logic [127:0] state,
  input  logic [127:0] round_key,
  input  logic         final_round,
  output logic [127:0] next_state
);
  logic [7:0] sr [16];
  logic [7:0] mc [16];
  always_comb begin
    // byte k sits at row k%4, column k/4; row r rotates left by r columns
    for (int k = 0; k < 16; k++)
      sr[k] = sbox(state[127-8*(k%4 + 4*((k/4 + k%4) % 4)) -: 8]);
    for (int c = 0; c < 4; c++) begin
      mc[4*c]   = xtime(sr[4*c]) ^ xtime(sr[4*c+1]) ^ sr[4*c+1] ^ sr[4*c+2] ^ sr[4*c+3];
      mc[4*c+1] = sr[4*c] ^ xtime(sr[4*c+1]) ^ xtime(sr[4*c+2]) ^ sr[4*c+2] ^ sr[4*c+3];
      mc[4*c+2] = sr[4*c] ^ sr[4*c+1] ^ xtime(sr[4*c+2]) ^ xtime(sr[4*c+3]) ^ sr[4*c+3];
      mc[4*c+3] = xtime(sr[4*c]) ^ sr[4*c] ^ sr[4*c+1] ^ sr[4*c+2] ^ xtime(sr[4*c+3]);
    end
    for (int k = 0; k < 16; k++)
      next_state[127-8*k -: 8] = (final_round ? sr[k] : mc[k]) ^ round_key[127-8*k -: 8];
  end
endmodule

// File: rtl/aes_key_expand.sv
// aes_key_expand: combinational key schedule producing every round key at once
module aes_key_expand import aes_pkg::*; #(
  parameter int N = 128,
  localparam int NR = nr_of(N)
) (
  input  logic [N-1:0]  key,
  output logic [127:0]  rk [NR+1]
);
  localparam int NK = N / 32;
  localparam int NW = 4 * (NR + 1);
  logic [31:0] w [NW];
  logic [31:0] t;
  always_comb begin
    t = '0;
    for (int i = 0; i < NK; i++) w[i] = key[N-1-32*i -: 32];
    for (int i = NK; i < NW; i++) begin
      t = w[i-1];
      if (i % NK == 0) t = sub_word({t[23:0], t[31:24]}) ^ {rcon(i / NK), 24'h0};
      else if (NK > 6 && i % NK == 4) t = sub_word(t);
      w[i] = w[i-NK] ^ t;
    end
  end
  always_comb
    for (int i = 0; i <= NR; i++) rk[i] = {w[4*i], w[4*i+1], w[4*i+2], w[4*i+3]};
endmodule

// File: rtl/aes_encrypt_iter.sv
// aes_encrypt_iter: iterative AES-128/192/256 encryptor, one round per clock
module aes_encrypt_iter import aes_pkg::*; #(
  parameter int N = 128,
  localparam int NR = nr_of(N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [127:0]  plaintext,
  input  logic [N-1:0]  key,
  output logic          busy,
  output logic          done,
  output logic [127:0]  ciphertext
);
  if (N != 128 && N != 192 && N != 256) begin : g_bad_n
    $error("aes_encrypt_iter: N must be 128, 192 or 256");
  end
  localparam logic [3:0] LAST = 4'(NR);
  fsm_e fsm_q, fsm_d;
  logic [3:0] rnd_q, rnd_d;
  logic [127:0] st_q, st_d, ct_q, ct_d, rs;
  logic [N-1:0] key_q, key_d;
  logic busy_q, busy_d, done_q, done_d;
  logic [127:0] rk [NR+1];
  aes_key_expand #(.N(N)) u_kx (.key(key_q), .rk(rk));
  aes_enc_round u_rnd (.state(st_q), .round_key(rk[rnd_q]), .final_round(rnd_q == LAST), .next_state(rs));
  always_comb begin
    fsm_d = fsm_q;
    rnd_d = rnd_q;
    st_d = st_q;
    key_d = key_q;
    busy_d = busy_q;
    done_d = 1'b0;
    ct_d = ct_q;
    // rk0 is the leading 128 key bits, taken from the live port since key_q is loading now
    if (fsm_q == IDLE && start) begin
      key_d = key;
      st_d = plaintext ^ key[N-1 -: 128];
      rnd_d = 4'd1;
      busy_d = 1'b1;
      fsm_d = ROUND;
    end else if (fsm_q == ROUND && rnd_q == LAST) begin
      ct_d = rs;
      done_d = 1'b1;
      busy_d = 1'b0;
      rnd_d = 4'd0;
      fsm_d = IDLE;
    end else if (fsm_q == ROUND) begin
      st_d = rs;
      rnd_d = rnd_q + 4'd1;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_q <= IDLE;
      rnd_q <= '0;
      st_q <= '0;
      key_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      ct_q <= '0;
    end else begin
      fsm_q <= fsm_d;
      rnd_q <= rnd_d;
      st_q <= st_d;
      key_q <= key_d;
      busy_q <= busy_d;
      done_q <= done_d;
      ct_q <= ct_d;
    end
  end
  assign busy = busy_q;
  assign done = done_q;
  assign ciphertext = ct_q;
endmodule

// File: tb/tb_aes_encrypt_iter.sv
// tb_aes_encrypt_iter: FIPS-197 vectors on N=128/192/256 instances with a done-driven scoreboard
module tb_aes_encrypt_iter;
  localparam logic [255:0] K128_B = 256'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [255:0] K128_C = 256'h000102030405060708090a0b0c0d0e0f;
  localparam logic [255:0] K192_C = 256'h000102030405060708090a0b0c0d0e0f1011121314151617;
  localparam logic [255:0] K256_C = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] PT_C   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT192  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT256  = 128'h8ea2b7ca516745bfeafc49904b496089;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start_a [3];
  logic [127:0] pt_a [3];
  logic [255:0] key_a [3];
  logic busy_a [3];
  logic done_a [3];
  logic [127:0] ct_a [3];
  logic [127:0] sb [3][$];
  logic [127:0] hold [3];
  int passed = 0;
  int total = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int NN = 128 + 64 * g;
    aes_encrypt_iter #(.N(NN)) dut (
      .clk(clk), .reset(reset), .start(start_a[g]), .plaintext(pt_a[g]),
      .key(key_a[g][NN-1:0]), .busy(busy_a[g]), .done(done_a[g]), .ciphertext(ct_a[g])
    );
  end
  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  function automatic logic [255:0] rnd256();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction
  task automatic launch(input int g, input logic [127:0] pt, input logic [255:0] k, input logic [127:0] exp);
    start_a[g] = 1'b1;
    pt_a[g] = pt;
    key_a[g] = k;
    sb[g].push_back(exp);
  endtask
  // returns on the negedge where done is seen; optional chained launch happens on that done cycle
  task automatic wait_done(input int g, input int nr, input bit rnd_in, input bit poke,
                           input bit chain, input logic [127:0] cpt, input logic [255:0] ckey,
                           input logic [127:0] cexp);
    int cnt;
    int bcnt = 0;
    for (cnt = 1; cnt <= 40; cnt++) begin
      @(negedge clk);
      start_a[g] = poke && cnt == 5;
      if (rnd_in || start_a[g]) begin
        pt_a[g] = rnd256()[127:0];
        key_a[g] = rnd256();
      end
      if (busy_a[g]) bcnt++;
      if (done_a[g]) break;
    end
    chk($sformatf("latency_g%0d", g), cnt, nr + 1);
    chk($sformatf("busy_cycles_g%0d", g), bcnt, nr);
    if (chain) launch(g, cpt, ckey, cexp);
  endtask
  always @(posedge clk) begin
    #1;
    for (int g = 0; g < 3; g++) begin
      if (reset) begin
        chk($sformatf("reset_state_g%0d", g), {busy_a[g], done_a[g], ct_a[g]}, '0);
        sb[g].delete();
        hold[g] = '0;
      end else if (done_a[g]) begin
        chk($sformatf("done_expected_g%0d", g), sb[g].size() != 0, 1);
        if (sb[g].size() != 0) begin
          hold[g] = sb[g].pop_front();
          chk($sformatf("ciphertext_g%0d", g), ct_a[g], hold[g]);
        end
      end else chk($sformatf("ct_hold_g%0d", g), ct_a[g], hold[g]);
    end
  end
  initial begin
    int seen;
    for (int g = 0; g < 3; g++) begin
      start_a[g] = 1'b0;
      pt_a[g] = '0;
      key_a[g] = '0;
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_busy", busy_a[0], 0);
    launch(0, PT_B, K128_B, CT_B);
    wait_done(0, 10, 0, 0, 0, '0, '0, '0);
    launch(0, PT_C, K128_C, CT128);
    wait_done(0, 10, 0, 0, 0, '0, '0, '0);
    launch(1, PT_C, K192_C, CT192);
    wait_done(1, 12, 0, 0, 0, '0, '0, '0);
    launch(2, PT_C, K256_C, CT256);
    wait_done(2, 14, 0, 0, 0, '0, '0, '0);
    launch(0, PT_B, K128_B, CT_B);
    wait_done(0, 10, 1, 0, 0, '0, '0, '0);
    launch(1, PT_C, K192_C, CT192);
    wait_done(1, 12, 1, 0, 0, '0, '0, '0);
    launch(2, PT_C, K256_C, CT256);
    wait_done(2, 14, 1, 0, 0, '0, '0, '0);
    launch(0, PT_C, K128_C, CT128);
    wait_done(0, 10, 0, 1, 1, PT_B, K128_B, CT_B);
    wait_done(0, 10, 0, 0, 0, '0, '0, '0);
    launch(0, PT_C, K128_C, CT128);
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      start_a[0] = 1'b0;
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", busy_a[0], 0);
    chk("abort_done", done_a[0], 0);
    chk("abort_ct", ct_a[0], 0);
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      seen |= int'(done_a[0]);
    end
    chk("no_done_after_abort", seen, 0);
    launch(0, PT_B, K128_B, CT_B);
    wait_done(0, 10, 0, 0, 0, '0, '0, '0);
    @(negedge clk);
    reset = 1'b1;
    start_a[0] = 1'b1;
    pt_a[0] = PT_C;
    key_a[0] = K128_C;
    @(negedge clk);
    reset = 1'b0;
    start_a[0] = 1'b0;
    chk("prio_busy", busy_a[0], 0);
    chk("prio_ct", ct_a[0], 0);
    @(negedge clk);
    chk("prio_idle_busy", busy_a[0], 0);
    chk("prio_idle_done", done_a[0], 0);
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
